// File: rtl/memory_round_ctrl_if.sv
// Player-facing bus of the memory-game round controller.
// master drives round requests and cell toggles; slave is the controller.
interface memory_round_ctrl_if;
  logic        start;
  logic [1:0]  level;
  logic        sel_valid;
  logic [4:0]  sel_idx;
  logic        submit;
  logic [8:0]  seq1;
  logic [15:0] seq2;
  logic [24:0] seq3;
  logic [24:0] player;
  logic        show;
  logic        busy;
  logic        answer;
  logic        answer_valid;

  modport master (
    output start, level, sel_valid, sel_idx, submit,
    input  seq1, seq2, seq3, player, show, busy, answer, answer_valid
  );

  modport slave (
    input  start, level, sel_valid, sel_idx, submit,
    output seq1, seq2, seq3, player, show, busy, answer, answer_valid
  );
endinterface

// File: rtl/memory_round_ctrl.sv
// Memory-game round controller: random target generation, timed display,
// player entry and judging. Optional ROUND_TIMEOUT_EN bounds the input phase.
module memory_round_ctrl #(
  parameter int unsigned SHOW_CYCLES   = 200_000_000,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned INPUT_TIMEOUT = 1_000_000_000
) (
  input logic           clk,
  input logic           reset,
  memory_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_SHOW, S_INPUT, S_JUDGE} state_t;

  localparam int unsigned SW = $clog2(SHOW_CYCLES + 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [1:0]    level_q, level_d;
  logic [24:0]   pattern_q, pattern_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [SW-1:0] show_cnt_q, show_cnt_d;
  logic [8:0]    seq1_q, seq1_d;
  logic [15:0]   seq2_q, seq2_d;
  logic [24:0]   seq3_q, seq3_d;
  logic [24:0]   player_q, player_d;
  logic          show_q, show_d;
  logic          busy_q, busy_d;
  logic          answer_q, answer_d;
  logic          answer_valid_q, answer_valid_d;

  logic [4:0]    n_cells;
  logic [2:0]    k_target;
  logic [4:0]    cand;

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(INPUT_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(INPUT_TIMEOUT - 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tout_q, tout_d;
`endif

  always_comb begin
    unique case (level_q)
      2'b01:   begin n_cells = 5'd9;  k_target = 3'd3; end
      2'b10:   begin n_cells = 5'd16; k_target = 3'd5; end
      default: begin n_cells = 5'd25; k_target = 3'd7; end
    endcase
  end

  assign cand = lfsr_q[4:0];

  always_comb begin
    state_d        = state_q;
    lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    level_d        = level_q;
    pattern_d      = pattern_q;
    cnt_d          = cnt_q;
    show_cnt_d     = '0;
    player_d       = player_q;
    answer_d       = answer_q;
    answer_valid_d = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    tcnt_d         = '0;
    tout_d         = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && bus.level != 2'b00) begin
          level_d   = bus.level;
          pattern_d = '0;
          player_d  = '0;
          answer_d  = 1'b0;
          cnt_d     = '0;
          state_d   = S_GEN;
        end
      end
      S_GEN: begin
        // Target count is checked on the registered count, so the last
        // placement is followed by one more GEN cycle before SHOW.
        if (cnt_q == k_target) begin
          state_d = S_SHOW;
        end else if (cand < n_cells && !pattern_q[cand]) begin
          pattern_d[cand] = 1'b1;
          cnt_d           = cnt_q + 3'd1;
        end
      end
      S_SHOW: begin
        if (show_cnt_q == SHOW_LAST) begin
          state_d = S_INPUT;
        end else begin
          show_cnt_d = show_cnt_q + 1'b1;
        end
      end
      S_INPUT: begin
        if (bus.sel_valid && bus.sel_idx < n_cells) begin
          player_d[bus.sel_idx] = ~player_q[bus.sel_idx];
        end
        if (bus.submit) begin
          state_d = S_JUDGE;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (tcnt_q == TO_LAST) begin
          tout_d  = 1'b1;
          state_d = S_JUDGE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_JUDGE: begin
`ifdef ROUND_TIMEOUT_EN
        answer_d = (player_q == pattern_q) && !tout_q;
`else
        answer_d = (player_q == pattern_q);
`endif
        answer_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    seq1_d = (level_d == 2'b01) ? pattern_d[8:0]  : '0;
    seq2_d = (level_d == 2'b10) ? pattern_d[15:0] : '0;
    seq3_d = (level_d == 2'b11) ? pattern_d       : '0;
    show_d = (state_d == S_SHOW);
    // busy stays up through the answer_valid cycle so it drops two edges after submit.
    busy_d = (state_d != S_IDLE) || (state_q == S_JUDGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED;
      level_q        <= 2'b00;
      pattern_q      <= '0;
      cnt_q          <= '0;
      show_cnt_q     <= '0;
      seq1_q         <= '0;
      seq2_q         <= '0;
      seq3_q         <= '0;
      player_q       <= '0;
      show_q         <= 1'b0;
      busy_q         <= 1'b0;
      answer_q       <= 1'b0;
      answer_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      level_q        <= level_d;
      pattern_q      <= pattern_d;
      cnt_q          <= cnt_d;
      show_cnt_q     <= show_cnt_d;
      seq1_q         <= seq1_d;
      seq2_q         <= seq2_d;
      seq3_q         <= seq3_d;
      player_q       <= player_d;
      show_q         <= show_d;
      busy_q         <= busy_d;
      answer_q       <= answer_d;
      answer_valid_q <= answer_valid_d;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
    end
  end
`endif

  assign bus.seq1         = seq1_q;
  assign bus.seq2         = seq2_q;
  assign bus.seq3         = seq3_q;
  assign bus.player       = player_q;
  assign bus.show         = show_q;
  assign bus.busy         = busy_q;
  assign bus.answer       = answer_q;
  assign bus.answer_valid = answer_valid_q;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Self-checking bench for memory_round_ctrl: predicts targets from an
// independent LFSR history and scoreboards judged answers.
module tb_memory_round_ctrl;
  localparam int unsigned SHOW_N = 10;
  localparam int unsigned TO_N   = 20;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  memory_round_ctrl_if m ();

  memory_round_ctrl #(
    .SHOW_CYCLES  (SHOW_N),
    .SEED         (SEED_V),
    .INPUT_TIMEOUT(TO_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (m.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: feedback is the parity of tap bits 16,14,13,11.
  logic [15:0] mdl;
  always @(posedge clk or posedge reset)
    if (reset) mdl <= SEED_V;
    else       mdl <= {mdl[14:0], ^(mdl & 16'hB400)};

  logic [15:0] hist [int];
  always @(negedge clk) hist[cyc] = mdl;

  int av_count = 0;
  always @(negedge clk) if (m.answer_valid === 1'b1) av_count++;

  bit exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [24:0] mp;
  int lvl_cur;

  function automatic int ncells(input int l);
    return (l == 1) ? 9 : (l == 2) ? 16 : 25;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] l, output int t);
    m.start = 1'b1;
    m.level = l;
    tick();
    m.start = 1'b0;
    m.level = 2'b00;
    t = cyc;
  endtask

  task automatic predict(input int t, input int l, output logic [24:0] pat, output int se);
    int k, n, j, c;
    logic [15:0] h;
    logic [4:0] cd;
    k = (l == 1) ? 3 : (l == 2) ? 5 : 7;
    n = ncells(l);
    j = t;
    c = 0;
    pat = '0;
    while (c < k && j < t + 5000) begin
      h = hist[j];
      cd = h[4:0];
      if (int'(cd) < n && !pat[cd]) begin
        pat[cd] = 1'b1;
        c++;
      end
      j++;
    end
    se = j + 1;
  endtask

  task automatic wait_show(output int s);
    int n = 0;
    while (m.show !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("show_rise_seen", {31'd0, m.show}, 32'd1);
    s = cyc;
  endtask

  task automatic run_gen(input logic [1:0] l, output logic [24:0] pat);
    int t, s, se;
    do_start(l, t);
    check("busy_after_start", {31'd0, m.busy}, 32'd1);
    check("player_cleared", {7'd0, m.player}, 32'd0);
    check("answer_cleared", {31'd0, m.answer}, 32'd0);
    wait_show(s);
    predict(t, int'(l), pat, se);
    check("show_rise_edge", s, se);
    check("seq1", {23'd0, m.seq1}, (l == 2'b01) ? {23'd0, pat[8:0]}  : 32'd0);
    check("seq2", {16'd0, m.seq2}, (l == 2'b10) ? {16'd0, pat[15:0]} : 32'd0);
    check("seq3", {7'd0,  m.seq3}, (l == 2'b11) ? {7'd0, pat}        : 32'd0);
    mp = '0;
    lvl_cur = int'(l);
  endtask

  task automatic wait_input(output int n);
    n = 0;
    while (m.show === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic toggle(input int idx);
    m.sel_valid = 1'b1;
    m.sel_idx   = 5'(idx);
    if (idx < ncells(lvl_cur)) mp[idx] = ~mp[idx];
    tick();
    m.sel_valid = 1'b0;
    check("player_after_toggle", {7'd0, m.player}, {7'd0, mp});
  endtask

  task automatic submit_round(input bit with_toggle, input int idx, input logic [24:0] pat);
    bit e;
    if (with_toggle) begin
      m.sel_valid = 1'b1;
      m.sel_idx   = 5'(idx);
      if (idx < ncells(lvl_cur)) mp[idx] = ~mp[idx];
    end
    exp_q.push_back(mp == pat);
    m.submit = 1'b1;
    tick();
    m.submit    = 1'b0;
    m.sel_valid = 1'b0;
    check("av_low_in_judge", {31'd0, m.answer_valid}, 32'd0);
    check("player_judged", {7'd0, m.player}, {7'd0, mp});
    tick();
    check("av_pulse", {31'd0, m.answer_valid}, 32'd1);
    check("busy_during_av", {31'd0, m.busy}, 32'd1);
    e = exp_q.pop_front();
    check("answer", {31'd0, m.answer}, {31'd0, e});
    tick();
    check("av_single_cycle", {31'd0, m.answer_valid}, 32'd0);
    check("busy_fall", {31'd0, m.busy}, 32'd0);
  endtask

  initial begin
    logic [24:0] p1, p2, p3;
    int n, last, extra, t;
    m.start = 1'b0;
    m.level = 2'b00;
    m.sel_valid = 1'b0;
    m.sel_idx = '0;
    m.submit = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seq1", {23'd0, m.seq1}, 32'd0);
    check("rst_seq2", {16'd0, m.seq2}, 32'd0);
    check("rst_seq3", {7'd0, m.seq3}, 32'd0);
    check("rst_player", {7'd0, m.player}, 32'd0);
    check("rst_show", {31'd0, m.show}, 32'd0);
    check("rst_busy", {31'd0, m.busy}, 32'd0);
    check("rst_answer", {31'd0, m.answer}, 32'd0);
    check("rst_av", {31'd0, m.answer_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Level 1, with an ignored start in the middle of SHOW.
    run_gen(2'b01, p1);
    check("l1_popcount", $countones(m.seq1), 32'd3);
    n = 0;
    while (m.show === 1'b1 && n < 100) begin
      if (n == 3) begin m.start = 1'b1; m.level = 2'b10; end
      else        begin m.start = 1'b0; m.level = 2'b00; end
      tick();
      n++;
    end
    m.start = 1'b0;
    m.level = 2'b00;
    check("show_length", n, SHOW_N);
    check("seq1_after_show_start", {23'd0, m.seq1}, {23'd0, p1[8:0]});
    check("seq2_after_show_start", {16'd0, m.seq2}, 32'd0);
    toggle(20);
    toggle(4);
    toggle(4);
    last = 0;
    for (int i = 0; i < 9; i++) if (p1[i]) last = i;
    for (int i = 0; i < last; i++) if (p1[i]) toggle(i);
    submit_round(1'b1, last, p1);

    // Holding and ignored level-0 start.
    repeat (3) tick();
    check("answer_hold", {31'd0, m.answer}, 32'd1);
    check("seq1_hold", {23'd0, m.seq1}, {23'd0, p1[8:0]});
    m.start = 1'b1;
    m.level = 2'b00;
    tick();
    m.start = 1'b0;
    check("lvl0_busy", {31'd0, m.busy}, 32'd0);
    check("lvl0_seq1_hold", {23'd0, m.seq1}, {23'd0, p1[8:0]});
    tick();
    check("lvl0_busy_later", {31'd0, m.busy}, 32'd0);

    // Level 2 correct entry.
    run_gen(2'b10, p2);
    check("l2_popcount", $countones(m.seq2), 32'd5);
    wait_input(n);
    check("l2_show_length", n, SHOW_N);
    for (int i = 0; i < 16; i++) if (p2[i]) toggle(i);
    submit_round(1'b0, 0, p2);

    // Level 3 wrong entry (one extra cell).
    run_gen(2'b11, p3);
    check("l3_popcount", $countones(m.seq3), 32'd7);
    wait_input(n);
    for (int i = 0; i < 25; i++) if (p3[i]) toggle(i);
    extra = 0;
    for (int i = 24; i >= 0; i--) if (!p3[i]) extra = i;
    toggle(extra);
    submit_round(1'b0, 0, p3);

    // Reset in the middle of SHOW.
    do_start(2'b01, t);
    wait_show(n);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_seq1", {23'd0, m.seq1}, 32'd0);
    check("mid_rst_player", {7'd0, m.player}, 32'd0);
    check("mid_rst_show", {31'd0, m.show}, 32'd0);
    check("mid_rst_busy", {31'd0, m.busy}, 32'd0);
    check("mid_rst_answer", {31'd0, m.answer}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (30) tick();
    check("no_av_after_reset", av_count, 32'd3);
    check("idle_after_reset", {31'd0, m.busy}, 32'd0);

`ifdef ROUND_TIMEOUT_EN
    begin
      int e;
      run_gen(2'b01, p1);
      wait_input(n);
      e = cyc;
      n = 0;
      while (m.answer_valid !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      check("timeout_av", {31'd0, m.answer_valid}, 32'd1);
      check("timeout_edge", cyc, e + TO_N + 1);
      check("timeout_answer", {31'd0, m.answer}, 32'd0);
      repeat (3) tick();
      check("timeout_av_count", av_count, 32'd4);
    end
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
